// File: rtl/ext_regbank_pkg.sv
// Shared types and default geometry for the ext_regbank register bank.
package ext_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_NUM_HW   = 4;
  localparam int DEF_HW_BASE  = 1;
  localparam int DEF_STAT_IDX = 9;
  localparam int DEF_MASK_IDX = 10;

endpackage

// File: rtl/ext_regbank_fsm.sv
// Four-phase bus handshake: one ACCESS cycle per chip-select, commit strobes
// are single-cycle and never repeat while cs stays high in DONE.
module ext_regbank_fsm
  import ext_regbank_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_cs,
  input  logic   i_read,
  output logic   o_ready,
  output logic   o_commit_wr,
  output logic   o_commit_rd,
  output state_e o_state
);

  state_e r_state;
  logic   r_ready;
  logic   r_commit_wr;
  logic   r_commit_rd;

  // Handshake state plus registered ready and commit strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_commit_wr <= 1'b0;
      r_commit_rd <= 1'b0;
    end else begin
      r_commit_wr <= 1'b0;
      r_commit_rd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_cs) begin
            r_state     <= ACCESS;
            r_ready     <= 1'b0;
            r_commit_wr <= ~i_read;
            r_commit_rd <= i_read;
          end
        end
        ACCESS: begin
          r_state <= DONE;
          r_ready <= 1'b1;
        end
        DONE: begin
          if (!i_cs) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_commit_wr = r_commit_wr;
  assign o_commit_rd = r_commit_rd;
  assign o_state     = r_state;

endmodule

// File: rtl/ext_regbank.sv
// Memory-mapped peripheral register bank with HW-owned slots and sticky W1C status.
// Optional registered interrupt output enabled by defining EXT_REGBANK_IRQ_EN.
module ext_regbank
  import ext_regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_HW   = DEF_NUM_HW,
  parameter int HW_BASE  = DEF_HW_BASE,
  parameter int STAT_IDX = DEF_STAT_IDX,
  parameter int MASK_IDX = DEF_MASK_IDX
) (
  input  logic                     clk,
  input  logic                     Ireset_n,
  input  logic                     cs,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ready,
  output logic                     err,
  input  logic [NUM_HW-1:0]        hw_we,
  input  logic [NUM_HW*DATA_W-1:0] hw_wdata,
  input  logic [DATA_W-1:0]        evt,
  output logic [DEPTH*DATA_W-1:0]  regs_out,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);

  state_e            w_state;
  logic              w_commit_wr;
  logic              w_commit_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] w_next [DEPTH];
  logic              w_in_range;
  logic [AW-1:0]     w_idx;

  ext_regbank_fsm u_fsm (
    .i_clk       (clk),
    .i_rst_n     (Ireset_n),
    .i_cs        (cs),
    .i_read      (read),
    .o_ready     (ready),
    .o_commit_wr (w_commit_wr),
    .o_commit_rd (w_commit_rd),
    .o_state     (w_state)
  );

  assign w_in_range = ((r_addr >> AW) == {ADDR_W{1'b0}});
  assign w_idx      = r_addr[AW-1:0];

  // Latch the request in IDLE; produce read data and error at the commit edge
  always_ff @(posedge clk or negedge Ireset_n) begin
    if (!Ireset_n) begin
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= {DATA_W{1'b0}};
      r_rdata <= {DATA_W{1'b0}};
      r_err   <= 1'b0;
    end else begin
      if (w_state == IDLE && cs) begin
        r_addr  <= address;
        r_wdata <= wdata;
      end
      if (w_commit_wr || w_commit_rd) begin
        r_err   <= ~w_in_range;
        r_rdata <= (w_commit_rd && w_in_range) ? r_regs[w_idx] : {DATA_W{1'b0}};
      end else if (w_state == DONE && !cs) begin
        r_rdata <= {DATA_W{1'b0}};
        r_err   <= 1'b0;
      end
    end
  end

  assign rdata = r_rdata;
  assign err   = r_err;

  for (genvar k = 0; k < DEPTH; k++) begin : g_reg
    if (k >= HW_BASE && k < HW_BASE + NUM_HW) begin : g_hw
      // Bus writes never reach HW-owned slots; only the peripheral load strobe does
      assign w_next[k] = hw_we[k-HW_BASE] ? hw_wdata[(k-HW_BASE)*DATA_W +: DATA_W] : r_regs[k];
    end else if (k == STAT_IDX) begin : g_stat
      logic w_hit;
      assign w_hit     = w_commit_wr && w_in_range && (w_idx == AW'(k));
      assign w_next[k] = (w_hit ? (r_regs[k] & ~r_wdata) : r_regs[k]) | evt;
    end else if (k == MASK_IDX) begin : g_mask
      logic w_hit;
      assign w_hit     = w_commit_wr && w_in_range && (w_idx == AW'(k));
      assign w_next[k] = w_hit ? r_wdata : r_regs[k];
    end else begin : g_plain
      logic w_hit;
      assign w_hit     = w_commit_wr && w_in_range && (w_idx == AW'(k));
      assign w_next[k] = w_hit ? r_wdata : r_regs[k];
    end
    assign regs_out[k*DATA_W +: DATA_W] = r_regs[k];
  end

  // Register array storage
  always_ff @(posedge clk or negedge Ireset_n) begin
    if (!Ireset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= w_next[k];
      end
    end
  end

`ifdef EXT_REGBANK_IRQ_EN
  logic r_irq;

  // Interrupt follows masked status one edge later
  always_ff @(posedge clk or negedge Ireset_n) begin
    if (!Ireset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_regs[AW'(STAT_IDX)] & r_regs[AW'(MASK_IDX)]);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule
